// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// countdown_pkg : state encoding and BCD helpers for the countdown timer
// Rev 1.0
// ============================================================================
package countdown_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic bcd_nibble_valid(input logic [3:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// bcd_down_digit : one loadable 0-9 BCD down-counter digit with borrow out
// Rev 1.0
// ============================================================================
module bcd_down_digit
  import countdown_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       ld_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o,
  output logic       borrow_o
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i) begin
      q_d = d_i;
    end else if (en_i) begin
      q_d = (q_q == 4'd0) ? BCD_MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o      = q_q;
  assign borrow_o = en_i & (q_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/bcd_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// bcd_countdown_ctrl : programmable BCD countdown timer (FSM, prescaler, preset)
// Rev 1.0
// ============================================================================
module bcd_countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter int PRESCALE    = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] load_val_i,
  input  logic                start_i,
  input  logic                pause_i,
  input  logic                clear_i,
  output logic [4*DIGITS-1:0] count_o,
  output logic [2:0]          state_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                load_err_o
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [CW-1:0] preset_q, preset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_err_q, load_err_d;

  logic [CW-1:0]     count_w;
  logic [CW-1:0]     dig_val;
  logic              dig_ld;
  logic [DIGITS-1:0] nib_ok;
  logic              load_ok;
  logic              tick_w;
  logic              wrap_w;

  // A tick only happens when the RUN branch below is the one that fires.
  assign tick_w = !clear_i && (state_q == ST_RUN) && !(pause_i && !start_i)
                  && (presc_q == PRESC_LAST);

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic en_w;
      logic borrow_w;

      if (gi == 0) begin : g_lsd
        assign en_w = tick_w;
      end else begin : g_upper
        assign en_w = g_digit[gi-1].borrow_w;
      end

      assign nib_ok[gi] = bcd_nibble_valid(load_val_i[4*gi +: 4]);

      bcd_down_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en_w),
        .ld_i     (dig_ld),
        .d_i      (dig_val[4*gi +: 4]),
        .q_o      (count_w[4*gi +: 4]),
        .borrow_o (borrow_w)
      );
    end
  endgenerate

  // Borrow out of the top digit means a tick arrived while the count was 0.
  assign wrap_w  = g_digit[DIGITS-1].borrow_w;
  assign load_ok = &nib_ok;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    preset_d   = preset_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    dig_ld     = 1'b0;
    dig_val    = load_val_i;

    if (clear_i) begin
      state_d = ST_IDLE;
      presc_d = '0;
      dig_ld  = 1'b1;
      dig_val = '0;
    end else if (load_i && (state_q != ST_RUN)) begin
      if (load_ok) begin
        preset_d = load_val_i;
        dig_ld   = 1'b1;
        presc_d  = '0;
        state_d  = ST_ARMED;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (start_i && (state_q == ST_ARMED)) begin
      if (count_w == '0) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        presc_d = '0;
      end
    end else if (start_i && (state_q == ST_PAUSE)) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (pause_i && !start_i) begin
        state_d = ST_PAUSE;
      end else begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        if (tick_w) begin
          if (wrap_w) begin
            dig_ld  = 1'b1;
            dig_val = preset_q;
          end else if (count_w == COUNT_ONE) begin
            done_d = 1'b1;
            if (AUTO_RELOAD == 0) begin
              state_d = ST_DONE;
            end
          end
        end
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      preset_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      preset_q   <= preset_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count_o    = count_w;
  assign state_o    = state_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign load_err_o = load_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bcd_countdown_ctrl : directed bench, DIGITS=2 PRESCALE=2, with and without reload
// Rev 1.0
// ============================================================================
module tb_bcd_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst, load, start, pause, clear;
  logic [7:0] load_val;
  logic [7:0] count, count_ar;
  logic [2:0] state, state_ar;
  logic       busy, busy_ar, done, done_ar, load_err, load_err_ar;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_countdown_ctrl #(.DIGITS(2), .PRESCALE(2), .AUTO_RELOAD(0)) u_dut (
    .clk(clk), .rst(rst), .load_i(load), .load_val_i(load_val), .start_i(start),
    .pause_i(pause), .clear_i(clear), .count_o(count), .state_o(state),
    .busy_o(busy), .done_o(done), .load_err_o(load_err)
  );

  bcd_countdown_ctrl #(.DIGITS(2), .PRESCALE(2), .AUTO_RELOAD(1)) u_dut_ar (
    .clk(clk), .rst(rst), .load_i(load), .load_val_i(load_val), .start_i(start),
    .pause_i(pause), .clear_i(clear), .count_o(count_ar), .state_o(state_ar),
    .busy_o(busy_ar), .done_o(done_ar), .load_err_o(load_err_ar)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0; load_val = 8'h00;
    cycle(); cycle();
    rst = 1'b0;
    checks++;
    if ({count, state, busy, done, load_err} !== 14'd0) begin
      errors++;
      $display("FAIL reset: count=%h state=%0d busy=%b done=%b err=%b, want all 0",
               count, state, busy, done, load_err);
    end
  endtask

  task automatic test_countdown();
    int ndone = 0;
    load = 1'b1; load_val = 8'h12; cycle(); load = 1'b0;
    checks++;
    if (count !== 8'h12 || state !== 3'd1) begin
      errors++; $display("FAIL load12: count=%h state=%0d, want 12/1", count, state);
    end
    start = 1'b1; cycle(); start = 1'b0;
    checks++;
    if (state !== 3'd2 || busy !== 1'b1 || count !== 8'h12) begin
      errors++; $display("FAIL start12: state=%0d busy=%b count=%h, want 2/1/12", state, busy, count);
    end
    for (int v = 11; v >= 0; v--) begin
      cycle(); if (done) ndone++;
      checks++;
      if (count !== bcd8(v + 1)) begin
        errors++; $display("FAIL cd_hold: count=%h, want %h", count, bcd8(v + 1));
      end
      cycle(); if (done) ndone++;
      checks++;
      if (count !== bcd8(v)) begin
        errors++; $display("FAIL cd_step: count=%h, want %h", count, bcd8(v));
      end
    end
    checks++;
    if (done !== 1'b1 || state !== 3'd4 || busy !== 1'b0) begin
      errors++; $display("FAIL cd_expire: done=%b state=%0d busy=%b, want 1/4/0", done, state, busy);
    end
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL cd_done_count: pulses=%0d, want 1", ndone);
    end
    cycle();
    checks++;
    if (done !== 1'b0 || state !== 3'd4 || count !== 8'h00) begin
      errors++; $display("FAIL cd_hold_done: done=%b state=%0d count=%h, want 0/4/00", done, state, count);
    end
    start = 1'b1; cycle(); start = 1'b0;
    checks++;
    if (state !== 3'd4 || count !== 8'h00 || done !== 1'b0) begin
      errors++; $display("FAIL done_start_ignored: state=%0d count=%h done=%b", state, count, done);
    end
  endtask

  task automatic test_load_err();
    clear = 1'b1; cycle(); clear = 1'b0;
    load = 1'b1; load_val = 8'h1A; cycle(); load = 1'b0;
    checks++;
    if (load_err !== 1'b1 || count !== 8'h00 || state !== 3'd0) begin
      errors++; $display("FAIL load_err_idle: err=%b count=%h state=%0d, want 1/00/0", load_err, count, state);
    end
    cycle();
    checks++;
    if (load_err !== 1'b0) begin
      errors++; $display("FAIL load_err_pulse: err=%b, want 0", load_err);
    end
    load = 1'b1; load_val = 8'h12; cycle();
    load_val = 8'h9F; cycle(); load = 1'b0;
    checks++;
    if (load_err !== 1'b1 || count !== 8'h12 || state !== 3'd1) begin
      errors++; $display("FAIL load_err_armed: err=%b count=%h state=%0d, want 1/12/1", load_err, count, state);
    end
    load = 1'b1; start = 1'b1; load_val = 8'h34; cycle(); load = 1'b0; start = 1'b0;
    checks++;
    if (state !== 3'd1 || count !== 8'h34) begin
      errors++; $display("FAIL load_start_prio: state=%0d count=%h, want 1/34", state, count);
    end
  endtask

  task automatic test_pause();
    clear = 1'b1; cycle(); clear = 1'b0;
    load = 1'b1; load_val = 8'h10; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (6) cycle();
    checks++;
    if (count !== 8'h07) begin
      errors++; $display("FAIL run_to_07: count=%h, want 07", count);
    end
    cycle();
    pause = 1'b1; cycle(); pause = 1'b0;
    checks++;
    if (state !== 3'd3 || count !== 8'h07 || busy !== 1'b1) begin
      errors++; $display("FAIL pause_enter: state=%0d count=%h busy=%b, want 3/07/1", state, count, busy);
    end
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (state !== 3'd3 || count !== 8'h07) begin
        errors++; $display("FAIL pause_hold: state=%0d count=%h, want 3/07", state, count);
      end
    end
    start = 1'b1; cycle(); start = 1'b0;
    checks++;
    if (state !== 3'd2 || count !== 8'h07) begin
      errors++; $display("FAIL resume: state=%0d count=%h, want 2/07", state, count);
    end
    cycle();
    checks++;
    if (count !== 8'h06) begin
      errors++; $display("FAIL resume_step: count=%h, want 06", count);
    end
    cycle(); cycle();
    checks++;
    if (count !== 8'h05) begin
      errors++; $display("FAIL resume_next: count=%h, want 05", count);
    end
  endtask

  task automatic test_clear();
    int ndone = 0;
    clear = 1'b1; cycle(); clear = 1'b0;
    if (done) ndone++;
    checks++;
    if (state !== 3'd0 || count !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_run: state=%0d count=%h busy=%b, want 0/00/0", state, count, busy);
    end
    repeat (4) begin
      cycle(); if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || state !== 3'd0 || count !== 8'h00) begin
      errors++; $display("FAIL clear_quiet: done_pulses=%0d state=%0d count=%h", ndone, state, count);
    end
  endtask

  task automatic test_auto_reload();
    logic [7:0] exp_ar [5] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02};
    logic [7:0] prev = 8'h03;
    load = 1'b1; load_val = 8'h03; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (count_ar !== prev || done_ar !== 1'b0) begin
        errors++; $display("FAIL ar_hold: count=%h done=%b, want %h/0", count_ar, done_ar, prev);
      end
      cycle();
      checks++;
      if (count_ar !== exp_ar[i] || done_ar !== (i == 2) || state_ar !== 3'd2) begin
        errors++; $display("FAIL ar_step%0d: count=%h done=%b state=%0d, want %h/%b/2",
                           i, count_ar, done_ar, state_ar, exp_ar[i], (i == 2));
      end
      if (i == 2) begin
        checks++;
        if (state !== 3'd4 || done !== 1'b1) begin
          errors++; $display("FAIL noar_stop: state=%0d done=%b, want 4/1", state, done);
        end
      end
      prev = exp_ar[i];
    end
    clear = 1'b1; cycle(); clear = 1'b0;
  endtask

  task automatic test_zero_start();
    load = 1'b1; load_val = 8'h00; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    checks++;
    if (state !== 3'd4 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_start: state=%0d done=%b busy=%b, want 4/1/0", state, done, busy);
    end
    checks++;
    if (state_ar !== 3'd4 || done_ar !== 1'b1) begin
      errors++; $display("FAIL zero_start_ar: state=%0d done=%b, want 4/1", state_ar, done_ar);
    end
    cycle();
    checks++;
    if (done !== 1'b0 || done_ar !== 1'b0) begin
      errors++; $display("FAIL zero_done_pulse: done=%b done_ar=%b, want 0/0", done, done_ar);
    end
  endtask

  task automatic test_reset_mid_run();
    clear = 1'b1; cycle(); clear = 1'b0;
    load = 1'b1; load_val = 8'h08; cycle(); load = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    load = 1'b1; load_val = 8'h55; cycle(); load = 1'b0;
    checks++;
    if (count !== 8'h08 || state !== 3'd2) begin
      errors++; $display("FAIL load_in_run: count=%h state=%0d, want 08/2", count, state);
    end
    repeat (7) cycle();
    checks++;
    if (count !== 8'h04) begin
      errors++; $display("FAIL run_to_04: count=%h, want 04", count);
    end
    rst = 1'b1; cycle(); rst = 1'b0;
    checks++;
    if ({count, state, busy, done, load_err} !== 14'd0) begin
      errors++; $display("FAIL rst_mid_run: count=%h state=%0d busy=%b done=%b err=%b",
                         count, state, busy, done, load_err);
    end
    start = 1'b1; cycle(); start = 1'b0;
    checks++;
    if (state !== 3'd0 || count !== 8'h00) begin
      errors++; $display("FAIL start_after_rst: state=%0d count=%h, want 0/00", state, count);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_load_err();
    test_pause();
    test_clear();
    test_auto_reload();
    test_zero_start();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
